// File: rtl/lane_color_mapper.sv
// Pipelined per-lane pixel colour mapper: hit flags, score digits and fretboard in, VGA RGB out.
// Two registered stages (source resolve, colour/flash/blank) with per-lane hit-flash timers.

module lcm_flash_lane #(
  parameter int FLASH_FRAMES = 6
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       hit,
  input  logic       frame_start,
  output logic [7:0] cnt
);

  // A hit always reloads, even on a frame boundary or while still flashing.
  always_ff @(posedge Clk) begin
    if (!Reset_n)                       cnt <= '0;
    else if (hit)                       cnt <= 8'(FLASH_FRAMES);
    else if (frame_start && cnt != '0)  cnt <= cnt - 8'd1;
  end

endmodule

module lane_color_mapper #(
  parameter int NUM_LANES    = 8,
  parameter int FLASH_FRAMES = 6,
  parameter int FLASH_BOOST  = 64
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 frame_start,
  input  logic [9:0]           DrawX,
  input  logic [9:0]           DrawY,
  input  logic                 blank_n,
  input  logic                 grad_en,
  input  logic                 is_num,
  input  logic [NUM_LANES-1:0] is_sr,
  input  logic [NUM_LANES-1:0] is_fb,
  input  logic [NUM_LANES-1:0] keyTrack,
  input  logic [NUM_LANES-1:0] lane_hit,
  output logic [7:0]           VGA_R,
  output logic [7:0]           VGA_G,
  output logic [7:0]           VGA_B,
  output logic                 blank_n_out
);

  localparam int STAGES = 2;
  localparam int LW     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam logic [8:0] BOOST = 9'(FLASH_BOOST);

  typedef enum logic [1:0] {SRC_BG, SRC_NUM, SRC_NOTE, SRC_FB} src_e;

  typedef struct packed {
    src_e                 src;
    logic [LW-1:0]        lane;
    logic [1:0]           pal;
    logic                 grad;
    logic [6:0]           y;
    logic [NUM_LANES-1:0] keys;
  } s1_t;

  s1_t                            s1_d, s1_q;
  logic [STAGES:1]                vld_pipe;
  logic [NUM_LANES-1:0][7:0]      flash_cnt;
  logic [LW-1:0]                  sr_lane, fb_lane;
  logic [1:0]                     sr_pal, fb_pal;
  logic                           held, flash_on;
  logic [23:0]                    pal_sel, pal_held, rgb;

  // Horizontal position and sub-row Y bits do not affect colour.
  logic unused_bits;
  assign unused_bits = ^{DrawX, DrawY[2:0]};

  function automatic logic [7:0] sat8(input logic [7:0] a, input logic [8:0] b);
    logic [8:0] s;
    s = {1'b0, a} + b;
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  function automatic logic [23:0] pal_color(input logic [1:0] p, input logic hold);
    logic [23:0] c;
    unique case (p)
      2'd3:    c = hold ? 24'hFF0000 : 24'hAF0000;
      2'd2:    c = hold ? 24'hFFFF00 : 24'hF2F200;
      2'd1:    c = hold ? 24'h0000FF : 24'h0000C9;
      default: c = hold ? 24'h00FD00 : 24'h00D600;
    endcase
    return c;
  endfunction

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      lcm_flash_lane #(.FLASH_FRAMES(FLASH_FRAMES)) u_flash (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .hit         (lane_hit[g]),
        .frame_start (frame_start),
        .cnt         (flash_cnt[g])
      );
    end
  endgenerate

  // Stage 1: ascending scan so the highest set lane overwrites lower ones.
  always_comb begin
    sr_lane = '0;
    sr_pal  = '0;
    fb_lane = '0;
    fb_pal  = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (is_sr[i]) begin
        sr_lane = LW'(i);
        sr_pal  = 2'(i);
      end
      if (is_fb[i]) begin
        fb_lane = LW'(i);
        fb_pal  = 2'(i);
      end
    end

    s1_d      = '0;
    s1_d.grad = grad_en;
    s1_d.y    = DrawY[9:3];
    s1_d.keys = keyTrack;
    if (is_num) begin
      s1_d.src = SRC_NUM;
    end else if (|is_sr) begin
      s1_d.src  = SRC_NOTE;
      s1_d.lane = sr_lane;
      s1_d.pal  = sr_pal;
    end else if (|is_fb) begin
      s1_d.src  = SRC_FB;
      s1_d.lane = fb_lane;
      s1_d.pal  = fb_pal;
    end else begin
      s1_d.src = SRC_BG;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      s1_q     <= '0;
      vld_pipe <= '0;
    end else begin
      s1_q     <= s1_d;
      vld_pipe <= {vld_pipe[STAGES-1:1], blank_n};
    end
  end

  // Stage 2: flash state is the live counter, not a copy carried with the pixel.
  always_comb begin
    held     = s1_q.keys[s1_q.lane];
    flash_on = |flash_cnt[s1_q.lane];
    pal_sel  = pal_color(s1_q.pal, held);
    pal_held = pal_color(s1_q.pal, 1'b1);
    rgb      = '0;
    unique case (s1_q.src)
      SRC_NUM:  rgb = 24'hFFFFFF;
      SRC_NOTE: rgb = flash_on ? {sat8(pal_sel[23:16], BOOST),
                                  sat8(pal_sel[15:8],  BOOST),
                                  sat8(pal_sel[7:0],   BOOST)} : pal_sel;
      SRC_FB:   rgb = flash_on ? 24'hFFFFFF : pal_held;
      default:  rgb = s1_q.grad ? {8'h00, sat8(8'h88, {2'b00, s1_q.y}), 8'h00} : 24'h000000;
    endcase
    if (!vld_pipe[1]) rgb = '0;
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      VGA_R <= '0;
      VGA_G <= '0;
      VGA_B <= '0;
    end else begin
      VGA_R <= rgb[23:16];
      VGA_G <= rgb[15:8];
      VGA_B <= rgb[7:0];
    end
  end

  assign blank_n_out = vld_pipe[STAGES];

endmodule

// File: tb/tb_lane_color_mapper.sv
// Directed + table-driven bench for lane_color_mapper (8-lane default, plus a 5-lane instance
// cross-checked against a cycle model on random flags).

module tb_lane_color_mapper;

  logic       Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic       Reset_n, frame_start, blank_n, grad_en, is_num;
  logic [9:0] DrawX, DrawY;
  logic [7:0] is_sr, is_fb, keyTrack, lane_hit;
  logic [7:0] VGA_R, VGA_G, VGA_B;
  logic       blank_n_out;

  logic       fs5, bl5, gr5, num5;
  logic [9:0] y5;
  logic [4:0] sr5, fb5, key5, hit5;
  logic [7:0] r5, g5, b5;
  logic       bo5;

  lane_color_mapper dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start), .DrawX(DrawX), .DrawY(DrawY),
    .blank_n(blank_n), .grad_en(grad_en), .is_num(is_num), .is_sr(is_sr), .is_fb(is_fb),
    .keyTrack(keyTrack), .lane_hit(lane_hit), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .blank_n_out(blank_n_out)
  );

  lane_color_mapper #(.NUM_LANES(5), .FLASH_FRAMES(3), .FLASH_BOOST(64)) dut5 (
    .Clk(Clk), .Reset_n(Reset_n), .frame_start(fs5), .DrawX(DrawX), .DrawY(y5),
    .blank_n(bl5), .grad_en(gr5), .is_num(num5), .is_sr(sr5), .is_fb(fb5),
    .keyTrack(key5), .lane_hit(hit5), .VGA_R(r5), .VGA_G(g5), .VGA_B(b5),
    .blank_n_out(bo5)
  );

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic        num;
    logic [7:0]  sr, fb, key;
    logic        bl, gr;
    logic [9:0]  y;
    logic [23:0] rgb;
    logic        ob;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [24:0] act, input logic [24:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got blank=%0b rgb=%06h, want blank=%0b rgb=%06h",
                  name, act[24], act[23:0], exp[24], exp[23:0]);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
    end
  endtask

  task automatic clr8();
    is_num = 0; is_sr = 0; is_fb = 0; keyTrack = 0; lane_hit = 0;
    frame_start = 0; blank_n = 1; grad_en = 0; DrawY = 0;
  endtask

  function automatic logic [24:0] out8();
    return {blank_n_out, VGA_R, VGA_G, VGA_B};
  endfunction

  // Independent reference for the 5-lane instance.
  function automatic logic [23:0] ref_pal(input int lane, input bit hold);
    case (lane % 4)
      0: return hold ? 24'h00FD00 : 24'h00D600;
      1: return hold ? 24'h0000FF : 24'h0000C9;
      2: return hold ? 24'hFFFF00 : 24'hF2F200;
      default: return hold ? 24'hFF0000 : 24'hAF0000;
    endcase
  endfunction

  function automatic logic [24:0] ref_out(input int kind, input int lane, input bit bl,
                                          input bit gr, input int y, input logic [4:0] keys,
                                          input int cnt);
    logic [23:0] c;
    int v;
    if (!bl) return 25'h0;
    case (kind)
      1: c = 24'hFFFFFF;
      2: begin
        c = ref_pal(lane, keys[lane]);
        if (cnt > 0)
          for (int j = 0; j < 3; j++) begin
            v = int'(c[j*8 +: 8]) + 64;
            c[j*8 +: 8] = (v > 255) ? 8'hFF : 8'(v);
          end
      end
      3: c = (cnt > 0) ? 24'hFFFFFF : ref_pal(lane, 1'b1);
      default: begin
        v = 136 + y;
        c = gr ? {8'h00, (v > 255) ? 8'hFF : 8'(v), 8'h00} : 24'h0;
      end
    endcase
    return {1'b1, c};
  endfunction

  int         m_kind, m_lane, m_y, nk, nl;
  bit         m_bl, m_gr;
  logic [4:0] m_keys;
  int         m_cnt[5];
  logic [24:0] m_out, nxt_out;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1'b1, 8'h81, 8'hFF, 8'h00, 1'b1, 1'b0, 10'd0,    24'hFFFFFF, 1'b1};
    tbl[1]  = '{1'b0, 8'h81, 8'h00, 8'h00, 1'b1, 1'b0, 10'd0,    24'hAF0000, 1'b1};
    tbl[2]  = '{1'b0, 8'h01, 8'h00, 8'h01, 1'b1, 1'b0, 10'd0,    24'h00FD00, 1'b1};
    tbl[3]  = '{1'b0, 8'h00, 8'h0C, 8'h00, 1'b1, 1'b0, 10'd0,    24'hFF0000, 1'b1};
    tbl[4]  = '{1'b0, 8'h02, 8'h80, 8'h00, 1'b1, 1'b0, 10'd0,    24'h0000C9, 1'b1};
    tbl[5]  = '{1'b0, 8'h40, 8'h00, 8'h40, 1'b1, 1'b0, 10'd0,    24'hFFFF00, 1'b1};
    tbl[6]  = '{1'b0, 8'h40, 8'h00, 8'hBF, 1'b1, 1'b0, 10'd0,    24'hF2F200, 1'b1};
    tbl[7]  = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 10'd1016, 24'h000000, 1'b1};
    tbl[8]  = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 10'd0,    24'h008800, 1'b1};
    tbl[9]  = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 10'd1016, 24'h00FF00, 1'b1};
    tbl[10] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 10'd959,  24'h00FF00, 1'b1};
    tbl[11] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 10'd15,   24'h008900, 1'b1};
    tbl[12] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 10'd1016, 24'h000000, 1'b0};
    tbl[13] = '{1'b1, 8'h04, 8'h00, 8'h04, 1'b0, 1'b0, 10'd0,    24'h000000, 1'b0};

    DrawX = 10'd100;
    fs5 = 0; bl5 = 0; gr5 = 0; num5 = 0; y5 = 0; sr5 = 0; fb5 = 0; key5 = 0; hit5 = 0;

    // Reset with every flag active, hits included
    Reset_n = 0; is_num = 1; blank_n = 1; grad_en = 1; is_sr = 8'hFF; is_fb = 8'hFF;
    keyTrack = 8'hFF; lane_hit = 8'hFF; frame_start = 1; DrawY = 10'd500;
    repeat (3) tick();
    chk("reset_hold", out8(), 25'h0);
    lane_hit = 0; frame_start = 0;
    Reset_n = 1;
    tick();
    chk("release_lat1", out8(), 25'h0);
    tick();
    chk("release_lat2", out8(), {1'b1, 24'hFFFFFF});

    // Static colour table (all counters idle)
    for (int i = 0; i < 14; i++) begin
      clr8();
      is_num = tbl[i].num; is_sr = tbl[i].sr; is_fb = tbl[i].fb; keyTrack = tbl[i].key;
      blank_n = tbl[i].bl; grad_en = tbl[i].gr; DrawY = tbl[i].y;
      tick(); tick();
      chk($sformatf("vec%0d", i), out8(), {tbl[i].ob, tbl[i].rgb});
    end

    // Flash on lane 5
    clr8();
    lane_hit = 8'h20; tick(); lane_hit = 0;
    is_fb = 8'h20; tick(); tick();
    chk("flash_fb", out8(), {1'b1, 24'hFFFFFF});
    frames(5); tick();
    chk("flash_cnt1", out8(), {1'b1, 24'hFFFFFF});
    frames(1); tick();
    chk("flash_done", out8(), {1'b1, 24'h0000FF});
    is_fb = 0; lane_hit = 8'h20; tick(); lane_hit = 0;
    is_sr = 8'h20; keyTrack = 0; tick(); tick();
    chk("flash_note_sat", out8(), {1'b1, 24'h4040FF});
    // Reset mid-flash clears the counter
    Reset_n = 0; tick(); Reset_n = 1;
    is_sr = 0; is_fb = 8'h20; tick(); tick();
    chk("reset_mid_flash", out8(), {1'b1, 24'h0000FF});

    // Collision and retrigger on lane 2
    clr8();
    is_fb = 8'h04;
    lane_hit = 8'h04; frame_start = 1; tick(); lane_hit = 0; frame_start = 0;
    frames(5); tick();
    chk("collide_cnt1", out8(), {1'b1, 24'hFFFFFF});
    frames(1); tick();
    chk("collide_done", out8(), {1'b1, 24'hFFFF00});
    lane_hit = 8'h04; tick(); lane_hit = 0;
    frames(5); tick();
    chk("retrig_pre", out8(), {1'b1, 24'hFFFFFF});
    lane_hit = 8'h04; tick(); lane_hit = 0;
    frames(5); tick();
    chk("retrig_cnt1", out8(), {1'b1, 24'hFFFFFF});
    frames(1); tick();
    chk("retrig_done", out8(), {1'b1, 24'hFFFF00});
    frames(10); tick();
    chk("idle_10", out8(), {1'b1, 24'hFFFF00});

    // 5-lane instance, directed
    bl5 = 1; sr5 = 5'h10; key5 = 5'h10; tick(); tick();
    chk("p5_lane4", {bo5, r5, g5, b5}, {1'b1, 24'h00FD00});
    sr5 = 5'h08; key5 = 5'h00; tick(); tick();
    chk("p5_lane3", {bo5, r5, g5, b5}, {1'b1, 24'hAF0000});

    // 5-lane instance vs cycle model on random flags
    Reset_n = 0; tick(); Reset_n = 1;
    m_kind = 0; m_lane = 0; m_y = 0; m_bl = 0; m_gr = 0; m_keys = 0; m_out = 25'h0;
    for (int i = 0; i < 5; i++) m_cnt[i] = 0;
    for (int k = 0; k < 300; k++) begin
      chk("rand5", {bo5, r5, g5, b5}, m_out);
      num5 = ($urandom_range(0, 7) == 0);
      sr5  = ($urandom_range(0, 1) == 1) ? 5'($urandom) : 5'h0;
      fb5  = 5'($urandom);
      key5 = 5'($urandom);
      bl5  = ($urandom_range(0, 7) != 0);
      gr5  = 1'($urandom);
      y5   = 10'($urandom);
      hit5 = ($urandom_range(0, 5) == 0) ? 5'(1 << $urandom_range(0, 4)) : 5'h0;
      fs5  = ($urandom_range(0, 2) == 0);

      nxt_out = ref_out(m_kind, m_lane, m_bl, m_gr, m_y, m_keys, m_cnt[m_lane]);
      nk = 0; nl = 0;
      if (num5) nk = 1;
      else if (sr5 != 0) begin
        nk = 2;
        for (int i = 4; i >= 0; i--) if (sr5[i]) begin nl = i; break; end
      end else if (fb5 != 0) begin
        nk = 3;
        for (int i = 4; i >= 0; i--) if (fb5[i]) begin nl = i; break; end
      end
      tick();
      m_out = nxt_out;
      m_kind = nk; m_lane = nl; m_bl = bl5; m_gr = gr5; m_y = int'(y5 >> 3); m_keys = key5;
      for (int i = 0; i < 5; i++)
        if (hit5[i]) m_cnt[i] = 3;
        else if (fs5 && m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
